// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } resultSrc_e;

  // One buffered FPU result: destination float register and its value.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } bufEntry_t;

  localparam int ENTRY_W = $bits(bufEntry_t);

  // Pick the writeback value; the unused 2'b11 encoding falls back to the ALU result.
  function automatic logic [XLEN-1:0] selectResult(
    input logic [1:0]      resultSrc,
    input logic [XLEN-1:0] aluResult,
    input logic [XLEN-1:0] readData,
    input logic [XLEN-1:0] pcPlus4
  );
    logic [XLEN-1:0] res;
    case (resultSrc_e'(resultSrc))
      RES_ALU: res = aluResult;
      RES_MEM: res = readData;
      RES_PC4: res = pcPlus4;
      default: res = aluResult;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// MEM/WB inputs, FPU result handshake and register-file write port.
interface writeback_arbiter_if;
  import wb_pkg::*;

  logic              wb_valid;
  logic              RegWrite;
  logic              RegWriteF;
  logic [1:0]        ResultSrc;
  logic [XLEN-1:0]   ALUResult;
  logic [XLEN-1:0]   ReadData;
  logic [XLEN-1:0]   PCPlus4;
  logic [REG_AW-1:0] Rd;
  logic              fpu_valid;
  logic [REG_AW-1:0] fpu_rd;
  logic [XLEN-1:0]   fpu_result;
  logic              fpu_ready;
  logic              stall;
  logic              WE;
  logic              WEF;
  logic [REG_AW-1:0] WA;
  logic [XLEN-1:0]   WB;

  // Producer side: pipeline, FPU and the register file observer.
  modport master (
    output wb_valid, RegWrite, RegWriteF, ResultSrc, ALUResult, ReadData, PCPlus4, Rd,
    output fpu_valid, fpu_rd, fpu_result,
    input  fpu_ready, stall, WE, WEF, WA, WB
  );

  // Arbiter side.
  modport slave (
    input  wb_valid, RegWrite, RegWriteF, ResultSrc, ALUResult, ReadData, PCPlus4, Rd,
    input  fpu_valid, fpu_rd, fpu_result,
    output fpu_ready, stall, WE, WEF, WA, WB
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding late FPU results until a writeback slot opens.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wrPtr_r;
  logic [AW-1:0]    rdPtr_r;
  logic [CW-1:0]    count_r;
  logic             doPush_s;
  logic             doPop_s;

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign doPush_s = push && !full;
  assign doPop_s  = pop && !empty;
  assign full     = (count_r == DEPTH_C);
  assign empty    = (count_r == {CW{1'b0}});
  assign count    = count_r;
  assign rdata    = mem_r[rdPtr_r];

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wrPtr_r <= {AW{1'b0}};
      rdPtr_r <= {AW{1'b0}};
    end else begin
      if (doPush_s) begin
        mem_r[wrPtr_r] <= wdata;
        wrPtr_r        <= wrPtr_r + AW'(1);
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + AW'(1);
      end
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: pipeline results win the register-file port, buffered
// FPU results drain on idle slots, and a starved buffer forces a one-cycle stall.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               reset,
  writeback_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic               pipeSlot_s;
  logic               pop_s;
  logic               push_s;
  logic               fifoFull_s;
  logic               fifoEmpty_s;
  logic [CW-1:0]      fifoCount_s;
  logic [CW-1:0]      countNext_s;
  logic [SW-1:0]      starveNext_s;
  logic [ENTRY_W-1:0] headBits_s;
  bufEntry_t          head_s;
  bufEntry_t          pushEntry_s;

  logic [SW-1:0]      starveCnt_r;
  logic               stall_r;
  logic               fpuReady_r;
  logic               we_r;
  logic               wef_r;
  logic [REG_AW-1:0]  wa_r;
  logic [XLEN-1:0]    wb_r;

  assign pushEntry_s = '{rd: bus.fpu_rd, data: bus.fpu_result};
  assign head_s      = bufEntry_t'(headBits_s);

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (pushEntry_s),
    .rdata (headBits_s),
    .full  (fifoFull_s),
    .empty (fifoEmpty_s),
    .count (fifoCount_s)
  );

  // Slot arbitration plus next values of the occupancy and starvation bookkeeping.
  always_comb begin
    pipeSlot_s   = 1'b0;
    pop_s        = 1'b0;
    push_s       = 1'b0;
    countNext_s  = fifoCount_s;
    starveNext_s = {SW{1'b0}};

    // A registered stall makes the held instruction yield its slot to the buffer.
    pipeSlot_s  = bus.wb_valid && !stall_r && (bus.RegWrite || bus.RegWriteF);
    pop_s       = !pipeSlot_s && !fifoEmpty_s;
    push_s      = bus.fpu_valid && fpuReady_r && !fifoFull_s;
    countNext_s = fifoCount_s + CW'(push_s) - CW'(pop_s);

    if (fifoEmpty_s || pop_s) begin
      starveNext_s = {SW{1'b0}};
    end else if (starveCnt_r == STARVE_MAX) begin
      starveNext_s = STARVE_MAX;
    end else begin
      starveNext_s = starveCnt_r + SW'(1);
    end
  end

  // Starvation counter, forced stall and FPU back-pressure, all from end-of-cycle state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starveCnt_r <= {SW{1'b0}};
      stall_r     <= 1'b0;
      fpuReady_r  <= 1'b1;
    end else begin
      starveCnt_r <= starveNext_s;
      stall_r     <= (starveNext_s == STARVE_MAX);
      fpuReady_r  <= (countNext_s < DEPTH_C);
    end
  end

  // Register-file write port; address and data hold on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r  <= 1'b0;
      wef_r <= 1'b0;
      wa_r  <= {REG_AW{1'b0}};
      wb_r  <= {XLEN{1'b0}};
    end else if (pipeSlot_s) begin
      // x0 is hardwired to zero, f0 is a real register.
      we_r  <= bus.RegWrite && (bus.Rd != {REG_AW{1'b0}});
      wef_r <= bus.RegWriteF;
      wa_r  <= bus.Rd;
      wb_r  <= selectResult(bus.ResultSrc, bus.ALUResult, bus.ReadData, bus.PCPlus4);
    end else if (pop_s) begin
      we_r  <= 1'b0;
      wef_r <= 1'b1;
      wa_r  <= head_s.rd;
      wb_r  <= head_s.data;
    end else begin
      we_r  <= 1'b0;
      wef_r <= 1'b0;
    end
  end

  assign bus.WE        = we_r;
  assign bus.WEF       = wef_r;
  assign bus.WA        = wa_r;
  assign bus.WB        = wb_r;
  assign bus.stall     = stall_r;
  assign bus.fpu_ready = fpuReady_r;

endmodule
